ex_operand_stage: RTL

- ID/EX pipeline register feeding the integer ALU.
- Captures a decoded instruction and resolves operand forwarding from the MEM and WB stages.
- Selects the A/B sources and builds the 10-bit ALU function code as {funct7, funct3}.
- Holds its contents under downstream backpressure, keeps held operands fresh from the forwarding paths, and supports a synchronous flush for branch redirect.

---
 rtl/ex_operand_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register for the integer ALU: captures a decoded instruction,
// resolves MEM/WB forwarding, selects operands and builds the ALU function code.
module ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [1:0]        op_kind_i,
    input  logic [1:0]        a_sel_i,
    input  logic              mem_we_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic [XLEN-1:0]   mem_data_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [XLEN-1:0]   a_o,
    output logic [XLEN-1:0]   b_o,
    output logic [9:0]        func_o,
    output logic [REG_AW-1:0] rd_addr_o
);

    localparam logic [1:0] OP_R = 2'b00;
    localparam logic [1:0] OP_I = 2'b01;

    function automatic logic [XLEN-1:0] fwd(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   data,
        input logic              m_we,
        input logic [REG_AW-1:0] m_rd,
        input logic [XLEN-1:0]   m_data,
        input logic              w_we,
        input logic [REG_AW-1:0] w_rd,
        input logic [XLEN-1:0]   w_data
    );
        if (addr == '0)
            return '0;
        else if (m_we && (m_rd == addr))
            return m_data;
        else if (w_we && (w_rd == addr))
            return w_data;
        else
            return data;
    endfunction

    logic              valid_reg;
    logic [XLEN-1:0]   a_reg;
    logic [XLEN-1:0]   b_reg;
    logic [9:0]        func_reg;
    logic [REG_AW-1:0] rd_reg;
    logic              a_from_rs1_reg;
    logic              b_from_rs2_reg;
    logic [REG_AW-1:0] src_addr_reg [2];
    logic [XLEN-1:0]   src_val_reg  [2];

    logic [REG_AW-1:0] in_addr  [2];
    logic [XLEN-1:0]   in_data  [2];
    logic [XLEN-1:0]   fwd_in   [2];
    logic [XLEN-1:0]   fwd_held [2];

    logic              capture;
    logic              hold;
    logic [XLEN-1:0]   a_next;
    logic [XLEN-1:0]   b_next;
    logic [9:0]        func_next;

    assign in_addr[0] = rs1_addr_i;
    assign in_addr[1] = rs2_addr_i;
    assign in_data[0] = rs1_data_i;
    assign in_data[1] = rs2_data_i;

    // Held operands keep the last forwarded value so a one-cycle producer pulse sticks.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_in[gi]   = fwd(in_addr[gi], in_data[gi], mem_we_i, mem_rd_i,
                                      mem_data_i, wb_we_i, wb_rd_i, wb_data_i);
            assign fwd_held[gi] = fwd(src_addr_reg[gi], src_val_reg[gi], mem_we_i, mem_rd_i,
                                      mem_data_i, wb_we_i, wb_rd_i, wb_data_i);
        end
    endgenerate

    assign ready_o = ~valid_reg | ready_i;
    assign capture = valid_i & ready_o & ~flush_i;
    assign hold    = valid_reg & ~ready_i;

    always_comb begin
        a_next    = '0;
        func_next = '0;
        case (a_sel_i)
            2'b00:   a_next = fwd_in[0];
            2'b01:   a_next = pc_i;
            default: a_next = '0;
        endcase
        b_next = (op_kind_i == OP_R) ? fwd_in[1] : imm_i;
        case (op_kind_i)
            OP_R:    func_next = {funct7_i, funct3_i};
            // Only shift-right immediates carry funct7; ADDI/SLLI etc. are cleaned.
            OP_I:    func_next = (funct3_i == 3'b101) ? {funct7_i, funct3_i} : {7'b0, funct3_i};
            default: func_next = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg      <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            func_reg       <= '0;
            rd_reg         <= '0;
            a_from_rs1_reg <= 1'b0;
            b_from_rs2_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                src_addr_reg[i] <= '0;
                src_val_reg[i]  <= '0;
            end
        end else if (flush_i) begin
            valid_reg <= 1'b0;
        end else if (capture) begin
            valid_reg      <= 1'b1;
            a_reg          <= a_next;
            b_reg          <= b_next;
            func_reg       <= func_next;
            rd_reg         <= rd_addr_i;
            a_from_rs1_reg <= (a_sel_i == 2'b00);
            b_from_rs2_reg <= (op_kind_i == OP_R);
            for (int i = 0; i < 2; i++) begin
                src_addr_reg[i] <= in_addr[i];
                src_val_reg[i]  <= fwd_in[i];
            end
        end else if (hold) begin
            for (int i = 0; i < 2; i++)
                src_val_reg[i] <= fwd_held[i];
            if (a_from_rs1_reg)
                a_reg <= fwd_held[0];
            if (b_from_rs2_reg)
                b_reg <= fwd_held[1];
        end else if (valid_reg && ready_i) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid_o   = valid_reg;
    assign a_o       = a_reg;
    assign b_o       = b_reg;
    assign func_o    = func_reg;
    assign rd_addr_o = rd_reg;

endmodule
